// File: rtl/sdac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdac_pkg
// Description : Shared types and constants for the serial DAC interface:
//               FSM state encoding, frame geometry and the frame-packing
//               helper used when a shadow code is loaded for shifting.
// Revision    : 1.0 - initial release
// ============================================================================
package sdac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } sdac_state_t;

  localparam int         FRAME_W      = 16;
  localparam logic [1:0] MODE_NORMAL  = 2'b00;
  localparam int         CODE_FIELD_W = FRAME_W - 2;
  localparam int         MAX_DATA_W   = 12;

  // Frame = {mode, code left-aligned in the 14-bit field, zero padding}.
  // The caller passes the code zero-extended to MAX_DATA_W bits.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [MAX_DATA_W-1:0] code,
    input int                    data_w
  );
    logic [CODE_FIELD_W-1:0] field;
    field = CODE_FIELD_W'(code) << (CODE_FIELD_W - data_w);
    return {MODE_NORMAL, field};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdac_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdac_rr_arb
// Description : Combinational round-robin arbiter. The search starts at the
//               channel following the one-hot last grant and wraps around.
// Ports       : req        - per-channel request vector
//               last_grant - one-hot channel granted most recently
//               grant      - one-hot winner (all zero when no request)
//               valid      - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module sdac_rr_arb #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  always_comb begin
    int last_idx;
    int idx;
    grant    = '0;
    valid    = 1'b0;
    last_idx = 0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (last_grant[i]) last_idx = i;
    end
    // Visit last_idx+1 .. last_idx+NUM_CH; the first requester wins.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (last_idx + k) % NUM_CH;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdac_intf.sv
`default_nettype none
// ============================================================================
// Module      : sdac_intf
// Description : Multi-channel serial DAC interface. Host writes land in
//               per-channel shadow registers and raise a pending flag; a
//               round-robin FSM sends one 16-bit frame per pending channel
//               over a shared SCLK/SDOUT with per-channel chip selects.
// Ports       : sp_clk, sp_rst_n         - clock, sync active-low reset
//               wr_val/wr_ch/wr_data/wr_bcast - host write port
//               rd_ch/rd_data             - shadow readback
//               dac_sclk/dac_cs_n/dac_sdout - serial DAC bus
//               busy/pend/done            - status
// Revision    : 1.0 - initial release
// ============================================================================
module sdac_intf
  import sdac_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 10,
  parameter  int CLK_DIV = 4,
  parameter  int CS_GAP  = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sp_clk,
  input  logic              sp_rst_n,
  input  logic              wr_val,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_bcast,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              dac_sclk,
  output logic [NUM_CH-1:0] dac_cs_n,
  output logic              dac_sdout,
  output logic              busy,
  output logic [NUM_CH-1:0] pend,
  output logic              done
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int HALF   = CLK_DIV / 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
    $fatal(1, "sdac_intf: NUM_CH=%0d outside 1..8", NUM_CH);
  end
  if (DATA_W < 8 || DATA_W > 12) begin : g_chk_data_w
    $fatal(1, "sdac_intf: DATA_W=%0d outside 8..12", DATA_W);
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_chk_clk_div
    $fatal(1, "sdac_intf: CLK_DIV=%0d must be even and >= 2", CLK_DIV);
  end
  if (CS_GAP < 1) begin : g_chk_cs_gap
    $fatal(1, "sdac_intf: CS_GAP=%0d must be >= 1", CS_GAP);
  end

  sdac_state_t       state_q, state_d;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] last_grant_q, last_grant_d;
  logic [NUM_CH-1:0] cur_q, cur_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NUM_CH-1:0] cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              sdout_q, sdout_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] arb_grant;
  logic              arb_valid;
  logic [DATA_W-1:0] snap_code;
  logic [FRAME_W-1:0] snap_frame;

  sdac_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req        (pend_q),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Shadow of the channel being loaded (cur_q is one-hot).
  always_comb begin
    snap_code = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_q[i]) snap_code = snap_code | shadow_q[i];
    end
    snap_frame = pack_frame(MAX_DATA_W'(snap_code), DATA_W);
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    cur_d        = cur_q;
    shreg_d      = shreg_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    sdout_d      = sdout_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_LOAD;
          cur_d   = arb_grant;
        end
      end
      ST_LOAD: begin
        shreg_d      = snap_frame;
        sdout_d      = snap_frame[FRAME_W-1];
        sclk_d       = 1'b1;
        cs_n_d       = ~cur_q;
        pend_d       = pend_q & ~cur_q;
        last_grant_d = cur_q;
        div_d        = '0;
        bit_d        = '0;
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b1;
          if (bit_q == 4'd15) begin
            state_d = ST_GAP;
            cs_n_d  = '1;
            sdout_d = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            sdout_d = shreg_q[FRAME_W-2];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
          if (div_q == DIV_MID) sclk_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host writes are applied last so a write in the LOAD cycle keeps the
    // granted channel pending while the snapshot still sees the old shadow.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_val && (wr_bcast || (wr_ch == CH_W'(i)))) begin
        shadow_d[i] = wr_data;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge sp_clk) begin
    if (!sp_rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      pend_q <= '0;
      // Last grant on the top channel makes the first search begin at channel 0.
      last_grant_q <= {1'b1, {(NUM_CH-1){1'b0}}};
      cur_q   <= '0;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b1;
      sdout_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      shreg_q      <= shreg_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      sdout_q      <= sdout_d;
      done_q       <= done_d;
    end
  end

  // Readback; an out-of-range channel matches no entry and returns 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_data = shadow_q[i];
    end
  end

  assign dac_sclk  = sclk_q;
  assign dac_cs_n  = cs_n_q;
  assign dac_sdout = sdout_q;
  assign busy      = (state_q != ST_IDLE);
  assign pend      = pend_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdac_intf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdac_intf
// Description : Directed self-checking bench for sdac_intf. Instance A uses
//               default parameters, instance B uses NUM_CH=1, DATA_W=12,
//               CLK_DIV=2. Frames are captured on falling SCLK edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdac_intf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic       a_wr_val = 1'b0, a_wr_bcast = 1'b0;
  logic [1:0] a_wr_ch = '0, a_rd_ch = '0;
  logic [9:0] a_wr_data = '0, a_rd_data;
  logic       a_sclk, a_sdout, a_busy, a_done;
  logic [3:0] a_cs_n, a_pend;

  sdac_intf u_dut_a (
    .sp_clk(clk), .sp_rst_n(rst_n),
    .wr_val(a_wr_val), .wr_ch(a_wr_ch), .wr_data(a_wr_data), .wr_bcast(a_wr_bcast),
    .rd_ch(a_rd_ch), .rd_data(a_rd_data),
    .dac_sclk(a_sclk), .dac_cs_n(a_cs_n), .dac_sdout(a_sdout),
    .busy(a_busy), .pend(a_pend), .done(a_done)
  );

  // Instance B (single channel, 12-bit, fastest SCLK)
  logic        b_wr_val = 1'b0, b_wr_bcast = 1'b0;
  logic [0:0]  b_wr_ch = '0, b_rd_ch = '0;
  logic [11:0] b_wr_data = '0, b_rd_data;
  logic        b_sclk, b_sdout, b_busy, b_done;
  logic [0:0]  b_cs_n, b_pend;

  sdac_intf #(.NUM_CH(1), .DATA_W(12), .CLK_DIV(2), .CS_GAP(2)) u_dut_b (
    .sp_clk(clk), .sp_rst_n(rst_n),
    .wr_val(b_wr_val), .wr_ch(b_wr_ch), .wr_data(b_wr_data), .wr_bcast(b_wr_bcast),
    .rd_ch(b_rd_ch), .rd_data(b_rd_data),
    .dac_sclk(b_sclk), .dac_cs_n(b_cs_n), .dac_sdout(b_sdout),
    .busy(b_busy), .pend(b_pend), .done(b_done)
  );

  // Monitor mux: sel_b picks which instance the capture tasks observe.
  logic       sel_b = 1'b0;
  logic [7:0] m_cs;
  logic       m_sclk, m_sdout, m_done;
  always_comb begin
    m_cs    = sel_b ? {7'h7F, b_cs_n} : {4'hF, a_cs_n};
    m_sclk  = sel_b ? b_sclk  : a_sclk;
    m_sdout = sel_b ? b_sdout : a_sdout;
    m_done  = sel_b ? b_done  : a_done;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [9:0] data, input logic bc);
    a_wr_val = 1'b1; a_wr_ch = ch; a_wr_data = data; a_wr_bcast = bc;
    tick();
    a_wr_val = 1'b0; a_wr_bcast = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (a_busy && n < 300) begin tick(); n++; end
  endtask

  // Cycles until some CS goes low; stops at 300.
  task automatic wait_cs_low(output int waited);
    waited = 0;
    while (m_cs == 8'hFF && waited < 300) begin tick(); waited++; end
  endtask

  function automatic int low_idx(input logic [7:0] cs);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--) if (!cs[i]) r = i;
    return r;
  endfunction

  // Called on the first CS-low sample. inj_kind 1 = write channel inj_ch of
  // instance A at frame cycle inj_at, 2 = assert reset at frame cycle inj_at
  // (left asserted for the caller to release).
  task automatic collect(input int inj_kind, input int inj_at, input logic [1:0] inj_ch,
                         input logic [9:0] inj_data, output logic [15:0] bits,
                         output int len, output int dones, output int onehot_ok);
    logic prev;
    bits = '0; len = 0; dones = 0; onehot_ok = 1; prev = 1'b1;
    while (m_cs != 8'hFF && len < 300) begin
      len++;
      if ($countones(~m_cs) != 1) onehot_ok = 0;
      if (prev && !m_sclk) bits = {bits[14:0], m_sdout};
      prev = m_sclk;
      if (m_done) dones++;
      if (inj_kind == 1 && len == inj_at + 1) begin
        a_wr_val = 1'b1; a_wr_ch = inj_ch; a_wr_data = inj_data; a_wr_bcast = 1'b0;
      end
      if (inj_kind == 2 && len == inj_at + 1) rst_n = 1'b0;
      tick();
      a_wr_val = 1'b0;
    end
    if (m_done) dones++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, len, dones, ok, quiet;
    logic [15:0] bits;

    // ---- Reset state ----
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_cs_n",  32'(a_cs_n), 32'hF);
    check("rst_sclk",  32'(a_sclk), 32'h1);
    check("rst_sdout", 32'(a_sdout), 32'h0);
    check("rst_busy",  32'(a_busy), 32'h0);
    check("rst_done",  32'(a_done), 32'h0);
    check("rst_pend",  32'(a_pend), 32'h0);
    check("rst_rd",    32'(a_rd_data), 32'h0);

    // ---- Single write ch1 = 0x2A5 ----
    write_a(2'd1, 10'h2A5, 1'b0);
    a_rd_ch = 2'd1; #1;
    check("wr1_pend", 32'(a_pend), 32'h2);
    check("wr1_rd",   32'(a_rd_data), 32'h2A5);
    wait_cs_low(waited);
    check("wr1_latency", 32'(waited), 32'd2);
    check("wr1_ch", 32'(low_idx(m_cs)), 32'd1);
    collect(0, 0, 2'd0, 10'h0, bits, len, dones, ok);
    check("wr1_bits",  32'(bits), 32'h2A50);
    check("wr1_len",   32'(len), 32'd64);
    check("wr1_done",  32'(dones), 32'd1);
    check("wr1_onehot", 32'(ok), 32'd1);
    check("wr1_idle_sdout", 32'(a_sdout), 32'h0);
    check("wr1_idle_sclk",  32'(a_sclk), 32'h1);

    // ---- Broadcast 0x155 from fresh reset ----
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    write_a(2'd0, 10'h155, 1'b1);
    a_rd_ch = 2'd3; #1;
    check("bc_pend", 32'(a_pend), 32'hF);
    check("bc_rd3",  32'(a_rd_data), 32'h155);
    for (int k = 0; k < 4; k++) begin
      wait_cs_low(waited);
      if (k == 0) check("bc_latency", 32'(waited), 32'd2);
      else        check("bc_gap_ge2", 32'(waited >= 2), 32'd1);
      check("bc_ch", 32'(low_idx(m_cs)), 32'(k));
      collect(0, 0, 2'd0, 10'h0, bits, len, dones, ok);
      check("bc_bits", 32'(bits), 32'h1550);
      check("bc_len",  32'(len), 32'd64);
      check("bc_pend_left", 32'(a_pend), 32'((4'hF << (k + 1)) & 4'hF));
    end

    // ---- Overwrite before grant: ch2 0x100 then 0x3FF ----
    wait_idle_a();
    write_a(2'd2, 10'h100, 1'b0);
    write_a(2'd2, 10'h3FF, 1'b0);
    wait_cs_low(waited);
    check("ow_ch", 32'(low_idx(m_cs)), 32'd2);
    collect(0, 0, 2'd0, 10'h0, bits, len, dones, ok);
    check("ow_bits", 32'(bits), 32'h3FF0);
    quiet = 1;
    repeat (40) begin tick(); if (a_cs_n != 4'hF) quiet = 0; end
    check("ow_single_frame", 32'(quiet), 32'd1);
    check("ow_pend", 32'(a_pend), 32'h0);

    // ---- Write to channel in flight: ch0 0x001, then 0x3FF mid-shift ----
    write_a(2'd0, 10'h001, 1'b0);
    wait_cs_low(waited);
    check("inf_ch", 32'(low_idx(m_cs)), 32'd0);
    collect(1, 20, 2'd0, 10'h3FF, bits, len, dones, ok);
    check("inf_bits1", 32'(bits), 32'h0010);
    check("inf_pend",  32'(a_pend), 32'h1);
    wait_cs_low(waited);
    check("inf_ch2", 32'(low_idx(m_cs)), 32'd0);
    collect(0, 0, 2'd0, 10'h0, bits, len, dones, ok);
    check("inf_bits2", 32'(bits), 32'h3FF0);
    a_rd_ch = 2'd0; #1;
    check("inf_rd0", 32'(a_rd_data), 32'h3FF);

    // ---- Reset mid-frame (period of bit 7) ----
    wait_idle_a();
    write_a(2'd2, 10'h0AA, 1'b0);
    write_a(2'd3, 10'h011, 1'b0);
    wait_cs_low(waited);
    check("mr_ch", 32'(low_idx(m_cs)), 32'd2);
    collect(2, 29, 2'd0, 10'h0, bits, len, dones, ok);
    rst_n = 1'b1;
    check("mr_len",   32'(len), 32'd30);
    check("mr_cs_n",  32'(a_cs_n), 32'hF);
    check("mr_sclk",  32'(a_sclk), 32'h1);
    check("mr_sdout", 32'(a_sdout), 32'h0);
    check("mr_pend",  32'(a_pend), 32'h0);
    check("mr_busy",  32'(a_busy), 32'h0);
    check("mr_done",  32'(a_done), 32'h0);
    a_rd_ch = 2'd3; #1;
    check("mr_rd3", 32'(a_rd_data), 32'h0);
    a_rd_ch = 2'd2; #1;
    check("mr_rd2", 32'(a_rd_data), 32'h0);
    quiet = 1;
    repeat (40) begin tick(); if (a_cs_n != 4'hF) quiet = 0; end
    check("mr_no_resume", 32'(quiet), 32'd1);

    // ---- Instance B: NUM_CH=1, DATA_W=12, CLK_DIV=2 ----
    sel_b = 1'b1;
    b_wr_val = 1'b1; b_wr_ch = 1'b1; b_wr_data = 12'h123;
    tick();
    b_wr_val = 1'b0;
    b_rd_ch = 1'b0; #1;
    check("b_badch_pend", 32'(b_pend), 32'h0);
    check("b_badch_rd",   32'(b_rd_data), 32'h0);
    b_wr_val = 1'b1; b_wr_ch = 1'b0; b_wr_data = 12'hABC;
    tick();
    b_wr_val = 1'b0;
    wait_cs_low(waited);
    check("b_latency", 32'(waited), 32'd2);
    collect(0, 0, 2'd0, 10'h0, bits, len, dones, ok);
    check("b_bits", 32'(bits), 32'h2AF0);
    check("b_len",  32'(len), 32'd32);
    check("b_done", 32'(dones), 32'd1);
    b_rd_ch = 1'b0; #1;
    check("b_rd0", 32'(b_rd_data), 32'hABC);
    b_rd_ch = 1'b1; #1;
    check("b_rd_oob", 32'(b_rd_data), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
